// File: rtl/fft_mag_frame_buffer_pkg.sv
// fft_pkg: shared FFT frame constants and the frame-buffer state encoding.
package fft_pkg;
    localparam int FFT_POINTS = 2048;
    localparam int MAG_W      = 16;
    localparam int IDX_W      = 11;
    localparam int NUM_BINS   = FFT_POINTS / 2;
    typedef enum logic [1:0] {CAPTURE, DRAIN, RESYNC} state_t;
endpackage

// File: rtl/fft_mag_frame_buffer_ram.sv
// mag_frame_ram: one write port, one registered read port with enable; maps onto block RAM.
module mag_frame_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/fft_mag_frame_buffer.sv
// fft_mag_frame_buffer: captures the one-sided bins of an FFT magnitude frame, tracks its peak,
// then streams the held frame out in bin order over valid/ready.
module fft_mag_frame_buffer #(
    parameter int DATA_W   = fft_pkg::MAG_W,
    parameter int IDX_W    = fft_pkg::IDX_W,
    parameter int NUM_BINS = fft_pkg::NUM_BINS,
    parameter int ADDR_W   = $clog2(NUM_BINS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic [DATA_W-1:0] frame_max,
    output logic              frame_dropped,
    output logic              frame_error,
    output logic              busy
);
    import fft_pkg::*;
    localparam logic [IDX_W:0]  NB_IDX  = (IDX_W+1)'(NUM_BINS);
    localparam logic [ADDR_W:0] NB_CNT  = (ADDR_W+1)'(NUM_BINS);
    localparam logic [ADDR_W:0] NB_SAT  = (ADDR_W+1)'(NUM_BINS + 1);
    localparam logic [ADDR_W:0] NB_LAST = (ADDR_W+1)'(NUM_BINS - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W:0]   r_cnt, r_rd_ptr, w_cnt_nxt;
    logic [DATA_W-1:0] r_max, r_frame_max, w_samp, w_max_nxt, w_rdata;
    logic [ADDR_W-1:0] r_out_index;
    logic r_in_frame, r_prime, r_out_valid, r_out_last, r_dropped, r_error;
    logic w_eof, w_we, w_re, w_adv, w_hs_last, w_in_frame_nxt, w_cap_ok, w_cap_err, w_drop;

    assign w_eof          = in_valid && in_last;
    assign w_we           = r_state == CAPTURE && in_valid && ({1'b0, in_index} < NB_IDX);
    // Saturate one past a full frame so heavy duplication can never wrap back to a valid count.
    assign w_cnt_nxt      = r_cnt + (ADDR_W+1)'(w_we && r_cnt != NB_SAT);
    assign w_samp         = in_data[DATA_W-1] ? '0 : in_data;
    assign w_max_nxt      = (w_we && w_samp > r_max) ? w_samp : r_max;
    assign w_in_frame_nxt = in_valid ? !in_last : r_in_frame;
    assign w_adv          = !r_out_valid || out_ready;
    // r_prime idles the first DRAIN cycle so the first beat appears two edges after the accepting in_last.
    assign w_re           = r_state == DRAIN && !r_prime && w_adv && r_rd_ptr != NB_CNT;
    assign w_hs_last      = r_out_valid && out_ready && r_out_last;

    always_comb begin
        w_state_nxt = r_state;
        w_drop      = 1'b0;
        w_cap_ok    = 1'b0;
        w_cap_err   = 1'b0;
        case (r_state)
            CAPTURE: begin
                w_cap_ok    = w_eof && w_cnt_nxt == NB_CNT;
                w_cap_err   = w_eof && w_cnt_nxt != NB_CNT;
                w_state_nxt = w_cap_ok ? DRAIN : CAPTURE;
            end
            DRAIN: begin
                w_drop = w_eof;
                if (w_hs_last) w_state_nxt = w_in_frame_nxt ? RESYNC : CAPTURE;
            end
            RESYNC: begin
                w_drop      = w_eof;
                w_state_nxt = w_eof ? CAPTURE : RESYNC;
            end
            default: w_state_nxt = CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= CAPTURE;
        else r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_max       <= '0;
            r_frame_max <= '0;
            r_rd_ptr    <= '0;
            r_in_frame  <= 1'b0;
            r_prime     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_index <= '0;
            r_dropped   <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_in_frame <= w_in_frame_nxt;
            r_dropped  <= w_drop;
            r_error    <= w_cap_err;
            r_prime    <= w_cap_ok;
            r_cnt      <= (r_state == CAPTURE && w_eof) ? '0 : w_cnt_nxt;
            r_max      <= (r_state == CAPTURE && w_eof) ? '0 : w_max_nxt;
            if (w_cap_ok) r_frame_max <= w_max_nxt;
            if (w_cap_ok) r_rd_ptr <= '0;
            else if (w_re) r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
            if (w_adv) begin
                r_out_valid <= w_re;
                r_out_last  <= w_re && r_rd_ptr == NB_LAST;
                if (w_re) r_out_index <= r_rd_ptr[ADDR_W-1:0];
            end
        end
    end

    mag_frame_ram #(.DATA_W(DATA_W), .DEPTH(NUM_BINS), .ADDR_W(ADDR_W)) u_ram (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(in_index[ADDR_W-1:0]),
        .i_wdata(in_data),
        .i_re   (w_re),
        .i_raddr(r_rd_ptr[ADDR_W-1:0]),
        .o_rdata(w_rdata)
    );

    // RAM read data is not reset, so it is masked whenever no beat is being presented.
    assign out_data      = r_out_valid ? w_rdata : '0;
    assign out_valid     = r_out_valid;
    assign out_index     = r_out_index;
    assign out_last      = r_out_last;
    assign frame_max     = r_frame_max;
    assign frame_dropped = r_dropped;
    assign frame_error   = r_error;
    assign busy          = r_state != CAPTURE;
endmodule
